// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encoding and address helpers for the cache controller
package cache_pkg;

  // Address helpers work on a fixed wide vector so any ADDR_WIDTH up to this fits.
  localparam int HELPER_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FILL_REQ,
    FILL_WAIT,
    WR_REQ,
    DONE
  } state_e;

  // Word-within-line offset: the low log_nb address bits, upper bits cleared.
  function automatic logic [HELPER_W-1:0] addr_offset(input logic [HELPER_W-1:0] addr,
                                                      input int log_nb);
    logic [HELPER_W-1:0] mask;
    mask = (HELPER_W'(1) << log_nb) - HELPER_W'(1);
    return addr & mask;
  endfunction

  // Line base: the address with its offset bits zeroed.
  function automatic logic [HELPER_W-1:0] line_base(input logic [HELPER_W-1:0] addr,
                                                    input int log_nb);
    logic [HELPER_W-1:0] mask;
    mask = (HELPER_W'(1) << log_nb) - HELPER_W'(1);
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/cache_stats_counter.sv
// rtl/cache_stats_counter.sv - saturating event counter used for hit/miss statistics
module cache_stats_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Increment on each event, sticking at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - write-through no-write-allocate cache FSM; CACHE_STATS_EN adds hit/miss counters
module cache_controller
  import cache_pkg::*;
#(
  parameter int LOG_NUM_LINES  = 2,
  parameter int LOG_NUM_BLOCKS = 1,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int STAT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_write,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
  output logic                  cpu_resp_valid,
  output logic [DATA_WIDTH-1:0] cpu_resp_rdata,
  output logic                  cache_write_en,
  output logic [DATA_WIDTH-1:0] cache_write_data,
  output logic [ADDR_WIDTH-1:0] cache_address,
  input  logic                  cache_hit,
  input  logic [DATA_WIDTH-1:0] cache_read_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_hits,
  output logic [STAT_WIDTH-1:0] stat_misses
`endif
);

  localparam logic [LOG_NUM_BLOCKS-1:0] LAST_BLOCK = {LOG_NUM_BLOCKS{1'b1}};

  state_e                    state_q, state_d;
  logic [LOG_NUM_BLOCKS-1:0] cnt_q, cnt_d;
  logic                      req_write_q, req_write_d;
  logic [ADDR_WIDTH-1:0]     req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0]     req_wdata_q, req_wdata_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;

  logic [HELPER_W-1:0]       base_w;
  logic [HELPER_W-1:0]       off_w;
  logic [ADDR_WIDTH-1:0]     fill_addr;
  logic [LOG_NUM_BLOCKS-1:0] req_offset;
  logic                      helper_unused;

  assign base_w        = line_base(HELPER_W'(req_addr_q), LOG_NUM_BLOCKS);
  assign off_w         = addr_offset(HELPER_W'(req_addr_q), LOG_NUM_BLOCKS);
  assign fill_addr     = base_w[ADDR_WIDTH-1:0] | ADDR_WIDTH'(cnt_q);
  assign req_offset    = off_w[LOG_NUM_BLOCKS-1:0];
  assign helper_unused = ^{base_w[HELPER_W-1:ADDR_WIDTH], off_w[HELPER_W-1:LOG_NUM_BLOCKS]};

  // Ready is withheld while reset is asserted so every output reads 0 during reset.
  assign cpu_req_ready  = (state_q == IDLE) && !rst;
  assign cpu_resp_valid = (state_q == DONE);
  assign cpu_resp_rdata = rdata_q;

  // Next-state, request latching, fill sequencing and cache/memory port drive.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    req_write_d      = req_write_q;
    req_addr_d       = req_addr_q;
    req_wdata_d      = req_wdata_q;
    rdata_d          = rdata_q;
    cache_write_en   = 1'b0;
    cache_write_data = '0;
    cache_address    = '0;
    mem_req_valid    = 1'b0;
    mem_req_write    = 1'b0;
    mem_req_addr     = '0;
    mem_req_wdata    = '0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req_valid) begin
          req_write_d = cpu_req_write;
          req_addr_d  = cpu_req_addr;
          req_wdata_d = cpu_req_wdata;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        cache_address = req_addr_q;
        if (req_write_q) begin
          // Write-through: update the cache only when the line is present.
          if (cache_hit) begin
            cache_write_en   = 1'b1;
            cache_write_data = req_wdata_q;
          end
          state_d = WR_REQ;
        end else if (cache_hit) begin
          rdata_d = cache_read_data;
          state_d = DONE;
        end else begin
          cnt_d   = '0;
          state_d = FILL_REQ;
        end
      end
      FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = fill_addr;
        if (mem_req_ready) begin
          state_d = FILL_WAIT;
        end
      end
      FILL_WAIT: begin
        cache_address = fill_addr;
        if (mem_resp_valid) begin
          cache_write_en   = 1'b1;
          cache_write_data = mem_resp_rdata;
          if (cnt_q == req_offset) begin
            rdata_d = mem_resp_rdata;
          end
          if (cnt_q == LAST_BLOCK) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + LOG_NUM_BLOCKS'(1);
            state_d = FILL_REQ;
          end
        end
      end
      WR_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = req_addr_q;
        mem_req_wdata = req_wdata_q;
        if (mem_req_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-request registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef CACHE_STATS_EN
  cache_stats_counter #(.WIDTH(STAT_WIDTH)) u_hits (
    .clk   (clk),
    .rst   (rst),
    .inc   ((state_q == LOOKUP) && cache_hit),
    .count (stat_hits)
  );

  cache_stats_counter #(.WIDTH(STAT_WIDTH)) u_misses (
    .clk   (clk),
    .rst   (rst),
    .inc   ((state_q == LOOKUP) && !cache_hit),
    .count (stat_misses)
  );
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - randomized scoreboard bench for cache_controller
module tb_cache_controller;

  localparam int LNL = 2;
  localparam int LNB = 1;
  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int SW  = 16;
  localparam int NB  = 2;
  localparam int NL  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req_valid = 1'b0;
  logic          cpu_req_ready;
  logic          cpu_req_write = 1'b0;
  logic [AW-1:0] cpu_req_addr = '0;
  logic [DW-1:0] cpu_req_wdata = '0;
  logic          cpu_resp_valid;
  logic [DW-1:0] cpu_resp_rdata;
  logic          cache_write_en;
  logic [DW-1:0] cache_write_data;
  logic [AW-1:0] cache_address;
  logic          cache_hit;
  logic [DW-1:0] cache_read_data;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic          mem_req_write;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_resp_valid = 1'b0;
  logic [DW-1:0] mem_resp_rdata = '0;
`ifdef CACHE_STATS_EN
  logic [SW-1:0] stat_hits;
  logic [SW-1:0] stat_misses;
`endif

  always #5 clk = ~clk;

  cache_controller #(
    .LOG_NUM_LINES(LNL), .LOG_NUM_BLOCKS(LNB), .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW), .STAT_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_write(cpu_req_write), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata), .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_rdata(cpu_resp_rdata), .cache_write_en(cache_write_en),
    .cache_write_data(cache_write_data), .cache_address(cache_address),
    .cache_hit(cache_hit), .cache_read_data(cache_read_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata)
`ifdef CACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  typedef struct {
    bit            is_load;
    bit            hit;
    logic [DW-1:0] rdata;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_mrd, n_mwr, n_cwr, acc_cyc;
  logic [AW-1:0] cur_base, last_waddr;
  logic [DW-1:0] last_wdata;

  bit rand_mode = 1'b0;
  int det_delay = 0;
  int stall_left = 0;
  bit pend = 1'b0;
  int pend_dly;
  logic [AW-1:0] pend_addr;
  bit have_hold = 1'b0;
  logic [AW+DW:0] hold_val;

  logic [DW-1:0] env_mem [256];
  logic [DW-1:0] ref_mem [256];
  bit            ref_valid [NL];
  logic [4:0]    ref_tag [NL];
  logic [DW-1:0] ref_last = '0;

  // Direct-mapped cache instance model driven by the controller's cache port.
  logic [DW-1:0] c_data [NL][NB];
  bit            c_valid [NL];
  logic [4:0]    c_tag [NL];

  assign cache_hit = c_valid[cache_address[2:1]] && (c_tag[cache_address[2:1]] == cache_address[7:3]);
  assign cache_read_data = c_data[cache_address[2:1]][cache_address[0]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NL; i++) c_valid[i] <= 1'b0;
    end else if (cache_write_en) begin
      c_data[cache_address[2:1]][cache_address[0]] <= cache_write_data;
      c_tag[cache_address[2:1]] <= cache_address[7:3];
      c_valid[cache_address[2:1]] <= 1'b1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Memory responder: random or deterministic ready, delayed read data, spurious responses.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        pend = 1'b0;
        mem_resp_valid = 1'b0;
      end else if (pend && pend_dly == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = env_mem[pend_addr];
        pend = 1'b0;
      end else if (pend) begin
        pend_dly--;
        mem_resp_valid = 1'b0;
      end else if (rand_mode && $urandom_range(0, 7) == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = $urandom;
      end else begin
        mem_resp_valid = 1'b0;
      end
      if (stall_left > 0) mem_req_ready = 1'b0;
      else if (rand_mode) mem_req_ready = ($urandom_range(0, 3) != 0);
      else mem_req_ready = 1'b1;
    end
  end

  // Monitor: observes memory traffic and pops the scoreboard on each completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cache_write_en) n_cwr++;
        if (mem_req_valid && mem_req_ready) begin
          if (mem_req_write) begin
            n_mwr++;
            last_waddr = mem_req_addr;
            last_wdata = mem_req_wdata;
            env_mem[mem_req_addr] = mem_req_wdata;
          end else begin
            chk("fill_addr", 64'(mem_req_addr), 64'(cur_base + AW'(n_mrd)));
            n_mrd++;
            pend = 1'b1;
            pend_addr = mem_req_addr;
            pend_dly = rand_mode ? int'($urandom_range(0, 3)) : det_delay;
          end
          have_hold = 1'b0;
        end else if (mem_req_valid) begin
          if (stall_left > 0) stall_left--;
          if (have_hold) chk("mem_req_hold", 64'({mem_req_write, mem_req_addr, mem_req_wdata}), 64'(hold_val));
          hold_val = {mem_req_write, mem_req_addr, mem_req_wdata};
          have_hold = 1'b1;
        end
        if (cpu_resp_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp act=1 exp=0");
          end else begin
            e = sb.pop_front();
            chk(e.is_load ? "load_rdata" : "store_rdata_hold", 64'(cpu_resp_rdata), 64'(e.rdata));
            chk("mem_reads", 64'(n_mrd), 64'((e.is_load && !e.hit) ? NB : 0));
            chk("mem_writes", 64'(n_mwr), 64'(e.is_load ? 0 : 1));
            chk("cache_writes", 64'(n_cwr), 64'(e.is_load ? (e.hit ? 0 : NB) : (e.hit ? 1 : 0)));
            if (!e.is_load) begin
              chk("store_addr", 64'(last_waddr), 64'(e.addr));
              chk("store_data", 64'(last_wdata), 64'(e.wdata));
            end
            if (e.lat >= 0) chk("latency", 64'(cyc - acc_cyc), 64'(e.lat));
          end
        end
      end
    end
  end

  // Issue one CPU request; on acceptance the reference model predicts the response.
  task automatic do_req(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    int idx;
    bit acc;
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b1;
    cpu_req_write = w;
    cpu_req_addr  = a;
    cpu_req_wdata = d;
    acc = 1'b0;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      if (cpu_req_ready) acc = 1'b1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout act=0 exp=1");
    end else begin
      idx = int'(a[2:1]);
      e.hit = ref_valid[idx] && (ref_tag[idx] == a[7:3]);
      e.is_load = !w;
      e.addr = a;
      e.wdata = d;
      if (w) begin
        e.rdata = ref_last;
        ref_mem[a] = d;
        e.lat = rand_mode ? -1 : 3;
      end else begin
        e.rdata = ref_mem[a];
        ref_last = ref_mem[a];
        e.lat = rand_mode ? -1 : (e.hit ? 2 : 2 + 2 * NB + stall_left + NB * det_delay);
        if (!e.hit) begin
          ref_valid[idx] = 1'b1;
          ref_tag[idx] = a[7:3];
        end
      end
      n_mrd = 0;
      n_mwr = 0;
      n_cwr = 0;
      acc_cyc = cyc;
      cur_base = {a[7:1], 1'b0};
      have_hold = 1'b0;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(sb.size()), 64'(0));
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cpu_req_valid = 1'b0;
    pend = 1'b0;
    mem_resp_valid = 1'b0;
    stall_left = 0;
    have_hold = 1'b0;
    sb.delete();
    for (int i = 0; i < NL; i++) ref_valid[i] = 1'b0;
    ref_last = '0;
    #1;
    chk("rst_ctl", 64'({cpu_req_ready, cpu_resp_valid, cache_write_en, mem_req_valid, mem_req_write}), 64'(0));
    chk("rst_rdata", 64'(cpu_resp_rdata), 64'(0));
    chk("rst_cache_port", 64'({cache_address, cache_write_data}), 64'(0));
    chk("rst_mem_port", 64'({mem_req_addr, mem_req_wdata}), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("idle_ready", 64'(cpu_req_ready), 64'(1));
  endtask

  initial begin
    logic [DW-1:0] v;
    bit acc;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      env_mem[i] = v;
      ref_mem[i] = v;
    end
    env_mem[8'h10] = 32'hA0; ref_mem[8'h10] = 32'hA0;
    env_mem[8'h11] = 32'hA1; ref_mem[8'h11] = 32'hA1;

    apply_reset();

    do_req(1'b0, 8'h10, '0);
    wait_idle();
    chk("line_word0", 64'(c_data[0][0]), 64'(32'hA0));
    chk("line_word1", 64'(c_data[0][1]), 64'(32'hA1));

    do_req(1'b0, 8'h11, '0);
    wait_idle();
    do_req(1'b1, 8'h11, 32'h55);
    wait_idle();
    do_req(1'b0, 8'h11, '0);
    wait_idle();
    do_req(1'b1, 8'h20, 32'h77);
    wait_idle();
    do_req(1'b0, 8'h20, '0);
    wait_idle();

    stall_left = 5;
    do_req(1'b0, 8'h30, '0);
    wait_idle();

    det_delay = 3;
    do_req(1'b0, 8'h44, '0);
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) acc = 1'b1;
    end
    chk("fill_started", 64'(acc), 64'(1));
    apply_reset();
    det_delay = 0;
    do_req(1'b0, 8'h44, '0);
    wait_idle();

    rand_mode = 1'b1;
    for (int n = 0; n < 150; n++) begin
      do_req($urandom_range(0, 9) < 3, AW'($urandom_range(0, 63)), $urandom);
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- FSM between the CPU load/store port and the direct-mapped write-through, no-write-allocate cache, with a single-ported backing memory behind it.
- Drives the cache's combinational lookup/write port.
- Performs whole-line fills on read misses and forwards every store to memory.
- Handles one CPU request at a time.

Parameters:
LOG_NUM_LINES, 2, log2 cache lines; must match the cache instance
LOG_NUM_BLOCKS, 1, log2 words per line; must match the cache instance
DATA_WIDTH, 32, word width
ADDR_WIDTH, 8, word address width
STAT_WIDTH, 16, statistics counter width (CACHE_STATS_EN only)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
cpu_req_valid  in  1  CPU request valid
cpu_req_ready  out  1  controller can accept a request
cpu_req_write  in  1  1 = store, 0 = load
cpu_req_addr  in  ADDR_WIDTH  word address
cpu_req_wdata  in  DATA_WIDTH  store data
cpu_resp_valid  out  1  one-cycle completion pulse (loads and stores)
cpu_resp_rdata  out  DATA_WIDTH  load data; valid with cpu_resp_valid
cache_write_en  out  1  to cache write_en
cache_write_data  out  DATA_WIDTH  to cache write_data
cache_address  out  ADDR_WIDTH  to cache address
cache_hit  in  1  from cache hit
cache_read_data  in  DATA_WIDTH  from cache read_data
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_write  out  1  1 = write, 0 = read
mem_req_addr  out  ADDR_WIDTH  memory word address
mem_req_wdata  out  DATA_WIDTH  memory write data
mem_resp_valid  in  1  read data returned (reads only)
mem_resp_rdata  in  DATA_WIDTH  read data

Behaviour:
- Reset (async, active-high): state=IDLE, block counter=0, every output and latched register 0. A reset mid-operation abandons any memory transaction with no completion. The cache instance shares rst, so a partial fill is invalidated.
- Latched request: req_write, req_addr, req_wdata are captured on the accept cycle. Offset = addr[LOG_NUM_BLOCKS-1:0]. Line base = addr with offset bits zeroed.
- cpu_req_ready=1 only in IDLE. A request is accepted when cpu_req_valid && cpu_req_ready.
- IDLE: on accept -> LOOKUP.
- LOOKUP:
  - cache_address=req_addr.
  - Load hit: capture cache_read_data into cpu_resp_rdata -> DONE.
  - Load miss: cnt=0 -> FILL_REQ.
  - Store hit: cache_write_en=1 and cache_write_data=req_wdata this cycle -> WR_REQ.
  - Store miss: no cache write (no-write-allocate) -> WR_REQ.
- FILL_REQ:
  - mem_req_valid=1, mem_req_write=0, mem_req_addr={line base, cnt}.
  - Hold all request signals stable until mem_req_ready; then -> FILL_WAIT.
- FILL_WAIT:
  - cache_address={line base, cnt}.
  - On mem_resp_valid: cache_write_en=1, cache_write_data=mem_resp_rdata.
  - If cnt==offset, also capture the data into cpu_resp_rdata.
  - If cnt==NUM_BLOCKS-1 -> DONE; else cnt+1 -> FILL_REQ.
  - cnt is LOG_NUM_BLOCKS wide and never wraps past the last word. Words are filled in ascending order from offset 0.
- WR_REQ:
  - mem_req_valid=1, mem_req_write=1, addr=req_addr, wdata=req_wdata, held until mem_req_ready.
  - Acceptance completes the store; no memory response is expected -> DONE.
- DONE: cpu_resp_valid=1 for exactly one cycle -> IDLE. cpu_resp_rdata holds its value until the next capture; it is 0 after reset, and stores do not modify it.
- Latency, assuming mem_req_ready is high in the request cycle:
  - Read hit: response 2 cycles after accept.
  - Store: 3 cycles after accept.
  - Read miss: 2 + 2·NUM_BLOCKS + total memory response wait cycles.
- Outside the cases above, cache_write_en=0 and mem_req_valid=0.
- mem_resp_valid outside FILL_WAIT is ignored.
- cpu_req_valid while busy is not accepted; the CPU holds the request.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined: adds outputs stat_hits and stat_misses, each STAT_WIDTH wide.
  - Each increments once per LOOKUP, loads and stores alike, based on cache_hit.
  - Counters saturate at all-ones and are cleared by rst.
- Undefined: the ports and counters are absent. Functional behaviour is identical.

Decomposition:
- Package cache_pkg holds:
  - the state enum (IDLE, LOOKUP, FILL_REQ, FILL_WAIT, WR_REQ, DONE);
  - helper functions for offset and line-base extraction from ADDR_WIDTH/LOG_NUM_BLOCKS.
- One natural sub-module: cache_stats_counter, a saturating counter instantiated twice under CACHE_STATS_EN.
- Everything else lives in the single FSM module.

Test Plan:
- Reset then load 0x10, memory returns 0xA0 then 0xA1 for 0x10/0x11: two read requests issued; cpu_resp_rdata=0xA0; cache holds both words.
- Load 0x11 after the previous fill: read hit; no mem_req_valid; resp 2 cycles after accept; rdata=0xA1.
- Store 0x11 ← 0x55 (hit): cache_write_en pulses in LOOKUP; one memory write to 0x11 with data 0x55; subsequent load 0x11 returns 0x55 with no memory read.
- Store 0x20 ← 0x77 (miss): memory write issued, cache_write_en never asserted; subsequent load 0x20 misses and fills.
- mem_req_ready held low 5 cycles during FILL_REQ: address and valid are stable throughout; resp delayed by exactly 5 cycles.
- Assert rst in FILL_WAIT: all outputs 0 immediately (async); next load to the same address misses again.
